// File: rtl/kbd_pkg.sv
// Shared scancodes, FSM encoding and grid defaults for the keyboard cursor controller.
package kbd_pkg;

  localparam int unsigned DEF_COLS = 80;
  localparam int unsigned DEF_ROWS = 60;

  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_BKSP  = 8'h66;
  localparam logic [7:0] KEY_1     = 8'h16;
  localparam logic [7:0] KEY_2     = 8'h1E;
  localparam logic [7:0] KEY_3     = 8'h26;
  localparam logic [7:0] KEY_4     = 8'h25;
  localparam logic [7:0] KEY_5     = 8'h2E;
  localparam logic [7:0] KEY_6     = 8'h36;
  localparam logic [7:0] KEY_7     = 8'h3D;
  localparam logic [7:0] KEY_8     = 8'h3E;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  // Returns {hit, colour index} for the digit-row colour keys.
  function automatic logic [3:0] color_decode(input logic [7:0] code);
    logic [3:0] r;
    r = '0;
    case (code)
      KEY_1: r = 4'b1_000;
      KEY_2: r = 4'b1_001;
      KEY_3: r = 4'b1_010;
      KEY_4: r = 4'b1_011;
      KEY_5: r = 4'b1_100;
      KEY_6: r = 4'b1_101;
      KEY_7: r = 4'b1_110;
      KEY_8: r = 4'b1_111;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/kbd_cursor_ctrl_event_detect.sv
// Scancode change detection, one-cycle event register and single-entry pending slot.
module kbd_event_detect
  import kbd_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] scancode,
  input  logic       busy,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       pend_valid,
  output logic [7:0] pend_code,
  output logic       evt_drop
);

  logic [7:0] prev_code;
  logic       store;
  logic       take;

  // Events park in the slot while a write is busy, or behind a pending event
  // that is being consumed this cycle so ordering is kept.
  assign store = evt_valid && (busy || pend_valid);
  assign take  = !busy && pend_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_code  <= '0;
      evt_valid  <= 1'b0;
      evt_code   <= '0;
      pend_valid <= 1'b0;
      pend_code  <= '0;
      evt_drop   <= 1'b0;
    end else begin
      prev_code <= scancode;
      evt_valid <= (scancode != prev_code);
      evt_code  <= scancode;
      evt_drop  <= store && pend_valid && !take;
      if (store) begin
        pend_valid <= 1'b1;
        pend_code  <= evt_code;
      end else if (take) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/kbd_cursor_ctrl.sv
// Decodes keyboard events into cursor moves, colour changes and frame-buffer writes.
module kbd_cursor_ctrl
  import kbd_pkg::*;
#(
  parameter int unsigned COLS = DEF_COLS,
  parameter int unsigned ROWS = DEF_ROWS,
  parameter int unsigned XW   = $clog2(COLS),
  parameter int unsigned YW   = $clog2(ROWS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [7:0]    scancode,
  input  logic          wr_ack,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y,
  output logic [2:0]    color,
  output logic          wr_req,
  output logic [XW-1:0] wr_x,
  output logic [YW-1:0] wr_y,
  output logic [2:0]    wr_color,
  output logic          evt_drop
);

  localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

  logic [0:0] state;
  logic       evt_valid, pend_valid;
  logic [7:0] evt_code, pend_code;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [3:0] col_dec;

  kbd_event_detect u_detect (
    .clock      (clock),
    .reset      (reset),
    .scancode   (scancode),
    .busy       (state == ST_WRITE),
    .evt_valid  (evt_valid),
    .evt_code   (evt_code),
    .pend_valid (pend_valid),
    .pend_code  (pend_code),
    .evt_drop   (evt_drop)
  );

  // A parked event always goes first; a fresh one arriving alongside is parked.
  always_comb begin
    cmd_valid = pend_valid || evt_valid;
    cmd_code  = pend_valid ? pend_code : evt_code;
    col_dec   = color_decode(cmd_code);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cur_x    <= '0;
      cur_y    <= '0;
      color    <= 3'd7;
      wr_req   <= 1'b0;
      wr_x     <= '0;
      wr_y     <= '0;
      wr_color <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (col_dec[3]) begin
              color <= col_dec[2:0];
            end else begin
              case (cmd_code)
                KEY_UP:    cur_y <= (cur_y == '0) ? Y_MAX : cur_y - 1'b1;
                KEY_DOWN:  cur_y <= (cur_y == Y_MAX) ? '0 : cur_y + 1'b1;
                KEY_LEFT:  cur_x <= (cur_x == '0) ? X_MAX : cur_x - 1'b1;
                KEY_RIGHT: cur_x <= (cur_x == X_MAX) ? '0 : cur_x + 1'b1;
                KEY_ESC: begin
                  cur_x <= '0;
                  cur_y <= '0;
                end
                KEY_SPACE, KEY_BKSP: begin
                  wr_req   <= 1'b1;
                  wr_x     <= cur_x;
                  wr_y     <= cur_y;
                  wr_color <= (cmd_code == KEY_SPACE) ? color : 3'd0;
                  state    <= ST_WRITE;
                end
                default: ;
              endcase
            end
          end
        end
        default: begin
          if (wr_ack) begin
            wr_req <= 1'b0;
            state  <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/kbd_cursor_ctrl.md
# kbd_cursor_ctrl

Consumes the release scancode held by the PS/2 keyboard handler and turns it into cursor, colour and cell-write commands for the VGA character grid. It detects each new scancode by value change, decodes it, moves a wrapping cursor, keeps a current colour and issues req/ack write transactions toward the frame-buffer writer. It sits between the keyboard handler and the frame-buffer port of the VGA controller.

## Interface
- COLS, 80, grid width in cells
- ROWS, 60, grid height in cells
- XW, $clog2(COLS), cursor x width (derived)
- YW, $clog2(ROWS), cursor y width (derived)

- clock  in  1  system clock, single clock domain
- reset  in  1  asynchronous, active-low reset
- scancode  in  8  release scancode from keyboard handler, held until next release
- wr_ack  in  1  frame-buffer writer accepts the current write
- cur_x  out  XW  cursor column, reset 0
- cur_y  out  YW  cursor row, reset 0
- color  out  3  current paint colour, reset 3'd7
- wr_req  out  1  write request, reset 0
- wr_x, wr_y  out  XW, YW  write cell address, reset 0
- wr_color  out  3  write data, reset 0
- evt_drop  out  1  one-cycle pulse, a pending event was overwritten, reset 0

## Operation
- Event detect: prev_code register, reset 8'h00, loads scancode every cycle; new event when scancode != prev_code. Re-release of the same key is not a new event (accepted limitation).
- Event register evt_code/evt_valid, one cycle after detect.
- Decode (set 2): 75 up, 72 down, 6B left, 74 right, 76 home (0,0), 16/1E/26/25/2E/36/3D/3E set color 0..7, 29 paint (write color at cursor), 66 erase (write 3'd0 at cursor). All other codes ignored.
- Movement wraps: left at x=0 -> COLS-1; right at COLS-1 -> 0; up at y=0 -> ROWS-1; down at ROWS-1 -> 0. No row carry on x wrap.
- FSM states IDLE, WRITE.
  - IDLE + evt_valid: move/home/colour applied immediately; paint/erase loads wr_x/wr_y/wr_color from current cursor/colour, asserts wr_req, -> WRITE.
  - WRITE: wr_req and wr_* held stable until wr_ack sampled high; then wr_req deasserts next edge, -> IDLE.
  - Events arriving in WRITE go to a single pending slot; a second one overwrites it (newest wins) and pulses evt_drop. On WRITE -> IDLE the pending event is processed in the following IDLE cycle.
- Cursor/colour never change while in WRITE; write address is the cursor at request time.
- Reset mid-write: wr_req drops asynchronously, pending slot and FSM cleared, all outputs to reset values.

## Timing
- scancode change at edge N -> evt_valid at N+1 -> cursor/colour/wr_req visible after edge N+2.
- wr_ack may be high in the same cycle wr_req first asserts; minimum WRITE occupancy 1 cycle.
- wr_ack ignored in IDLE.
- Back-to-back events one cycle apart in IDLE both applied, in order.
- Pending event applied 1 cycle after returning to IDLE (2 cycles after wr_ack edge).

## Structure
- Package kbd_pkg: scancode localparams (KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT, KEY_ESC, KEY_SPACE, KEY_BKSP, KEY_1..KEY_8), FSM state encoding, default COLS/ROWS.
- Sub-module kbd_event_detect: prev_code compare, event register, pending slot with drop pulse; top holds decode, cursor counters and FSM.

## Test plan
- Reset, scancode 8'h74 -> cur_x=1 after 2 edges; scancode then 8'h6B -> cur_x=0; again 8'h6B after 8'h00 -> cur_x=79.
- Cursor at (0,59), scancode 8'h72 -> cur_y=0, cur_x unchanged.
- scancode 8'h26 then 8'h29, wr_ack tied 0 -> wr_req=1, wr_x/wr_y=cursor, wr_color=2, held stable 20 cycles; wr_ack pulse -> wr_req=0 next edge.
- During WRITE feed 8'h74 then 8'h75 -> evt_drop pulses once; after ack only up move applied (cur_y decremented, cur_x unchanged).
- Same scancode 8'h74 held 100 cycles -> exactly one move.
- Assert reset low mid-WRITE -> wr_req=0, cursor (0,0), color 7 immediately; 8'h29 after release -> new write at (0,0) color 7.
